// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator at the decode/execute boundary
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter int AUTO_DECODE = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [31:0]     instr,
   input  logic [2:0]      immsrc,
   input  logic            stall,
   input  logic            flush,
   output logic [XLEN-1:0] imm_out,
   output logic            imm_valid,
   output logic            imm_err
);

   localparam logic [2:0] FMT_I   = 3'b000;
   localparam logic [2:0] FMT_S   = 3'b001;
   localparam logic [2:0] FMT_B   = 3'b010;
   localparam logic [2:0] FMT_J   = 3'b011;
   localparam logic [2:0] FMT_U   = 3'b100;
   localparam logic [2:0] FMT_Z   = 3'b101;
   localparam logic [2:0] FMT_SH  = 3'b110;
   localparam logic [2:0] FMT_RSV = 3'b111;

   // Raw signed fields; the size casts below sign-extend them to XLEN.
   logic signed [11:0] i_raw;
   logic signed [11:0] s_raw;
   logic signed [12:0] b_raw;
   logic signed [20:0] j_raw;
   logic signed [31:0] u_raw;

   assign i_raw = instr[31:20];
   assign s_raw = {instr[31:25], instr[11:7]};
   assign b_raw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign j_raw = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign u_raw = {instr[31:12], 12'b0};

   logic [2:0]      fmt;
   logic            shamt_5b;
   logic [XLEN-1:0] ext;
   logic            ext_err;

   always_comb begin
      fmt      = immsrc;
      shamt_5b = (XLEN == 32);
      if (AUTO_DECODE != 0) begin
         case (instr[6:0])
            7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0010011: fmt = (instr[13:12] == 2'b01) ? FMT_SH : FMT_I;
            7'b0011011: begin
               // Word shifts on RV64 only ever shift by 0..31.
               fmt      = (XLEN == 64) ? ((instr[13:12] == 2'b01) ? FMT_SH : FMT_I) : FMT_RSV;
               shamt_5b = 1'b1;
            end
            7'b0100011:             fmt = FMT_S;
            7'b1100011:             fmt = FMT_B;
            7'b1101111:             fmt = FMT_J;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1110011:             fmt = instr[14] ? FMT_Z : FMT_I;
            default:                fmt = FMT_RSV;
         endcase
      end
   end

   always_comb begin
      ext     = '0;
      ext_err = 1'b0;
      case (fmt)
         FMT_I:  ext = XLEN'(i_raw);
         FMT_S:  ext = XLEN'(s_raw);
         FMT_B:  ext = XLEN'(b_raw);
         FMT_J:  ext = XLEN'(j_raw);
         FMT_U:  ext = XLEN'(u_raw);
         FMT_Z:  ext = XLEN'(instr[19:15]);
         FMT_SH: ext = shamt_5b ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
         default: begin
            ext     = '0;
            ext_err = 1'b1;
         end
      endcase
   end

   logic [XLEN-1:0] imm_d,   imm_q;
   logic            valid_d, valid_q;
   logic            err_d,   err_q;

   always_comb begin
      imm_d   = ext;
      valid_d = in_valid;
      err_d   = in_valid & ext_err;
      if (flush) begin
         imm_d   = '0;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (stall) begin
         imm_d   = imm_q;
         valid_d = valid_q;
         err_d   = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         imm_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         imm_q   <= imm_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign imm_out   = imm_q;
   assign imm_valid = valid_q;
   assign imm_err   = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe in three configurations
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, in_valid, stall, flush;
   logic [31:0] instr;
   logic [2:0]  immsrc;

   logic [31:0] imm0, imm1;
   logic [63:0] imm2;
   logic        v0, e0, v1, e1, v2, e2;

   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .immsrc(immsrc),
      .stall(stall), .flush(flush), .imm_out(imm0), .imm_valid(v0), .imm_err(e0));
   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .immsrc(immsrc),
      .stall(stall), .flush(flush), .imm_out(imm1), .imm_valid(v1), .imm_err(e1));
   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(0)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .immsrc(immsrc),
      .stall(stall), .flush(flush), .imm_out(imm2), .imm_valid(v2), .imm_err(e2));

   typedef struct {
      int          sel;
      logic [63:0] imm;
      logic        v;
      logic        e;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   exp_t        cur;
   logic [63:0] a_imm;
   logic        a_v, a_e;

   // Monitor: one expectation per clock edge, sampled 2 time units after it.
   always @(posedge clk) begin
      #2;
      if (q.size() > 0) begin
         cur = q.pop_front();
         case (cur.sel)
            0:       begin a_imm = {32'b0, imm0}; a_v = v0; a_e = e0; end
            1:       begin a_imm = {32'b0, imm1}; a_v = v1; a_e = e1; end
            default: begin a_imm = imm2;          a_v = v2; a_e = e2; end
         endcase
         n_chk++;
         if (a_imm !== cur.imm || a_v !== cur.v || a_e !== cur.e) begin
            n_fail++;
            $display("FAIL %s dut%0d: got imm=%h valid=%b err=%b, expected imm=%h valid=%b err=%b",
                     cur.name, cur.sel, a_imm, a_v, a_e, cur.imm, cur.v, cur.e);
         end
      end
   end

   task automatic step(input string name, input int sel, input logic rst, input logic fl,
                       input logic st, input logic iv, input logic [2:0] src, input logic [31:0] ins,
                       input logic [63:0] ei, input logic ev, input logic ee);
      exp_t x;
      reset    = rst;
      flush    = fl;
      stall    = st;
      in_valid = iv;
      immsrc   = src;
      instr    = ins;
      x.sel = sel; x.imm = ei; x.v = ev; x.e = ee; x.name = name;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      immsrc = 3'b000; instr = 32'h0;

      step("reset0", 0, 1, 0, 0, 0, 3'b000, 32'h0, 64'h0, 0, 0);
      step("reset1", 1, 1, 0, 0, 0, 3'b000, 32'h0, 64'h0, 0, 0);
      step("reset2", 2, 1, 0, 0, 0, 3'b000, 32'h0, 64'h0, 0, 0);

      // XLEN=32, format from immsrc
      step("i_neg1",   0, 0, 0, 0, 1, 3'b000, 32'hFFF00093, 64'hFFFFFFFF, 1, 0);
      step("s_neg4",   0, 0, 0, 0, 1, 3'b001, 32'hFE20AE23, 64'hFFFFFFFC, 1, 0);
      step("j_neg2",   0, 0, 0, 0, 1, 3'b011, 32'hFFFFF0EF, 64'hFFFFFFFE, 1, 0);
      step("b_neg8",   0, 0, 0, 0, 1, 3'b010, 32'hFE000CE3, 64'hFFFFFFF8, 1, 0);
      step("u_lui",    0, 0, 0, 0, 1, 3'b100, 32'h123452B7, 64'h12345000, 1, 0);
      step("z_zext",   0, 0, 0, 0, 1, 3'b101, 32'hFFFFFFFF, 64'h0000001F, 1, 0);
      step("sh_zext",  0, 0, 0, 0, 1, 3'b110, 32'hFFFFFFFF, 64'h0000001F, 1, 0);
      step("rsv_v1",   0, 0, 0, 0, 1, 3'b111, 32'hFFF00093, 64'h0, 1, 1);
      step("rsv_v0",   0, 0, 0, 0, 0, 3'b111, 32'hFFF00093, 64'h0, 0, 0);
      step("i_load",   0, 0, 0, 0, 1, 3'b000, 32'hFFF00093, 64'hFFFFFFFF, 1, 0);
      step("stall1",   0, 0, 0, 1, 0, 3'b001, 32'h00100093, 64'hFFFFFFFF, 1, 0);
      step("stall2",   0, 0, 0, 1, 1, 3'b111, 32'h00200093, 64'hFFFFFFFF, 1, 0);
      step("stall3",   0, 0, 0, 1, 1, 3'b000, 32'h00300093, 64'hFFFFFFFF, 1, 0);
      step("flush_st", 0, 0, 1, 1, 1, 3'b000, 32'hFFF00093, 64'h0, 0, 0);
      step("iv0_load", 0, 0, 0, 0, 0, 3'b000, 32'h00500093, 64'h00000005, 0, 0);

      // XLEN=32, format from opcode decode; immsrc=111 must be ignored
      step("a_lui",    1, 0, 0, 0, 1, 3'b111, 32'h123452B7, 64'h12345000, 1, 0);
      step("a_undef",  1, 0, 0, 0, 1, 3'b111, 32'h0000007F, 64'h0, 1, 1);
      step("a_slli",   1, 0, 0, 0, 1, 3'b111, 32'h01F09093, 64'h0000001F, 1, 0);
      step("a_srai",   1, 0, 0, 0, 1, 3'b111, 32'h41F0D093, 64'h0000001F, 1, 0);
      step("a_addi",   1, 0, 0, 0, 1, 3'b111, 32'h41F08093, 64'h0000041F, 1, 0);
      step("a_csrrwi", 1, 0, 0, 0, 1, 3'b111, 32'h300FD0F3, 64'h0000001F, 1, 0);
      step("a_csrrw",  1, 0, 0, 0, 1, 3'b111, 32'h300F90F3, 64'h00000300, 1, 0);
      step("a_jal",    1, 0, 0, 0, 1, 3'b111, 32'hFFFFF0EF, 64'hFFFFFFFE, 1, 0);
      step("a_beq",    1, 0, 0, 0, 1, 3'b111, 32'hFE000CE3, 64'hFFFFFFF8, 1, 0);
      step("a_sw",     1, 0, 0, 0, 1, 3'b111, 32'hFE20AE23, 64'hFFFFFFFC, 1, 0);
      step("a_lw",     1, 0, 0, 0, 1, 3'b111, 32'hFFF02083, 64'hFFFFFFFF, 1, 0);
      step("a_auipc",  1, 0, 0, 0, 1, 3'b111, 32'h00001097, 64'h00001000, 1, 0);
      step("a_op32w",  1, 0, 0, 0, 1, 3'b111, 32'h0000101B, 64'h0, 1, 1);

      // XLEN=64, format from immsrc
      step("w_i_neg1", 2, 0, 0, 0, 1, 3'b000, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1, 0);
      step("w_reset",  2, 1, 1, 1, 1, 3'b000, 32'hFFF00093, 64'h0, 0, 0);
      step("w_u_sext", 2, 0, 0, 0, 1, 3'b100, 32'h80000037, 64'hFFFFFFFF80000000, 1, 0);
      step("w_shamt6", 2, 0, 0, 0, 1, 3'b110, 32'h03F00093, 64'h000000000000003F, 1, 0);
      step("w_z",      2, 0, 0, 0, 1, 3'b101, 32'hFFFFFFFF, 64'h000000000000001F, 1, 0);

      in_valid = 1'b0;
      stall    = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, registered immediate generator for the pipelined RISC-V core. It extracts and sign- or zero-extends the immediate for every RV32I/RV64I format, including CSR zimm and shift amounts, to XLEN bits. The immediate format comes from an explicit control field or from the block's own opcode decode. It sits at the decode→execute boundary and owns that boundary's immediate register, with stall, flush and valid tracking.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- AUTO_DECODE, 0, 0 = format from `immsrc`; 1 = format from opcode decode, `immsrc` ignored.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  decode-stage instruction is valid.
- instr  input  32  full instruction word.
- immsrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SHAMT, 111 reserved.
- stall  input  1  hold execute-stage register.
- flush  input  1  insert bubble.
- imm_out  output  XLEN  registered extended immediate.
- imm_valid  output  1  imm_out belongs to a valid instruction.
- imm_err  output  1  registered: a valid instruction had a reserved or undecodable format.

## Operation
- Combinational extract (s = instr[31], sign-extended to XLEN):
  - I: {s…, instr[31:20]}
  - S: {s…, instr[31:25], instr[11:7]}
  - B: {s…, instr[7], instr[30:25], instr[11:8], 0}
  - J: {s…, instr[19:12], instr[20], instr[30:21], 0}
  - U: {s…(XLEN>32 only), instr[31:12], 12'b0}
  - Z: zero-extend instr[19:15].
  - SHAMT: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - 111: value 0, error = 1.
- AUTO_DECODE=1 opcode map (instr[6:0]):
  - 0000011, 1100111 → I.
  - 0010011 → SHAMT if funct3 ∈ {001,101}, else I.
  - 0011011 (XLEN=64 only) → SHAMT if funct3 ∈ {001,101}, else I; SHAMT uses instr[24:20] here.
  - 0100011 → S; 1100011 → B; 1101111 → J; 0110111, 0010111 → U.
  - 1110011 → Z if funct3[2]=1, else I.
  - Any other opcode → value 0, error = 1.
- Register update priority per rising edge: reset > flush > stall > load.
  - reset or flush: imm_out=0, imm_valid=0, imm_err=0.
  - stall: all outputs hold.
  - load: imm_out ← extracted value; imm_valid ← in_valid; imm_err ← in_valid & error.
- When in_valid=0, imm_out is still loaded with the extracted value, but imm_valid and imm_err are 0.

## Timing
- Reset values: imm_out=0, imm_valid=0, imm_err=0.
- Latency: instr/in_valid sampled at edge N appear on outputs after edge N; one cycle, no bypass.
- Stall held for k cycles: outputs frozen k cycles. The upstream stage must hold instr during stall; input changes during stall are not captured.
- flush and stall together: flush wins, outputs cleared.
- reset mid-stream: outputs cleared on the next edge regardless of stall/flush; first valid output is one cycle after reset deasserts with in_valid=1.
- immsrc changes with no stall: take effect on the next edge, no extra latency.
- Throughput: one instruction per cycle.

## Test plan
- XLEN=32, AUTO_DECODE=0, immsrc=000, instr=0xFFF00093, in_valid=1 → next cycle imm_out=0xFFFFFFFF, imm_valid=1, imm_err=0.
- immsrc=001, instr=0xFE20AE23 (sw imm −4) → imm_out=0xFFFFFFFC. Then immsrc=011, instr=0xFFFFF0EF (jal −2) → imm_out=0xFFFFFFFE on the following cycle (back-to-back).
- AUTO_DECODE=1, instr=0x123452B7 (lui 0x12345) → imm_out=0x12345000. Then instr=0x0000007F (undefined opcode) → imm_out=0, imm_err=1, imm_valid=1.
- Load I of −1, then hold stall=1 for 3 cycles while instr changes → outputs unchanged. Assert flush with stall still high → next edge imm_valid=0, imm_out=0.
- immsrc=111 with in_valid=1 → imm_err=1, imm_out=0. Same with in_valid=0 → imm_err=0, imm_valid=0.
- XLEN=64, AUTO_DECODE=0, immsrc=000, instr=0xFFF00093 → imm_out=0xFFFFFFFFFFFFFFFF. Assert reset during that cycle → all outputs 0 on the next edge.
